// File: rtl/mux_scan_nto1.sv
// Registered N:1 mux with manual select or round-robin masked scan, valid/ready output.
// Optional MUX_SCAN_PARITY_EN adds out_par, the XOR of the captured sample.
module mux_scan_nto1 #(
  parameter int N_CH    = 16,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic                   out_par,
`endif
  output logic                   sel_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  // Assert asynchronously, release two edges after rst_n rises.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  logic [1:0]         state, state_d;
  logic [SEL_W-1:0]   ptr, ptr_d, nxt, cap_ch;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic               cap, err_d, free, any_en;
  logic [DATA_W-1:0]  cap_data;

  assign free   = !out_valid || out_ready;
  assign any_en = |ch_mask;

  // Round-robin search: first set mask bit after ptr, wrapping; smallest offset wins.
  always_comb begin
    int j;
    nxt = '0;
    for (int i = N_CH; i >= 1; i--) begin
      j = (int'(ptr) + i) % N_CH;
      if (ch_mask[SEL_W'(j)]) nxt = SEL_W'(j);
    end
  end

  always_comb begin
    cap_data = '0;
    for (int k = 0; k < N_CH; k++)
      if (cap_ch == SEL_W'(k)) cap_data = in_data[k*DATA_W +: DATA_W];
  end

  always_comb begin
    cap     = 1'b0;
    cap_ch  = ptr;
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    err_d   = 1'b0;
    if (!mode) begin
      state_d = S_IDLE;
      if (free) begin
        if (int'(sel) < N_CH) begin
          cap    = 1'b1;
          cap_ch = sel;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      case (state)
        S_IDLE: if (any_en && free) begin
          cap     = 1'b1;
          cap_ch  = nxt;
          ptr_d   = nxt;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (!out_valid) state_d = S_IDLE;
          else if (out_ready) begin
            if (dwell != '0) begin
              cnt_d   = dwell;
              state_d = S_DWELL;
            end else if (any_en) begin
              cap    = 1'b1;
              cap_ch = nxt;
              ptr_d  = nxt;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DWELL: begin
          // The last dwell cycle performs the idle search so exactly dwell cycles stay empty.
          if (!any_en) state_d = S_IDLE;
          else if (cnt <= DWELL_W'(1)) begin
            cap     = 1'b1;
            cap_ch  = nxt;
            ptr_d   = nxt;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt - DWELL_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      ptr       <= SEL_W'(N_CH - 1);
      cnt       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
      sel_err <= err_d;
      if (cap) begin
        out_data  <= cap_data;
        out_ch    <= cap_ch;
        out_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
        out_par   <= ^cap_data;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Directed bench for mux_scan_nto1: manual, backpressure, scan/dwell, masks, mode switch, reset, range error.
module tb_mux_scan_nto1;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic         mode, out_ready;
  logic [3:0]   sel, out_ch;
  logic [15:0]  ch_mask;
  logic [7:0]   dwell, out_data;
  logic         out_valid, sel_err;

  logic [95:0]  in_data12;
  logic [3:0]   sel12, out_ch12;
  logic [7:0]   out_data12;
  logic         out_valid12, sel_err12;
`ifdef MUX_SCAN_PARITY_EN
  logic         out_par, out_par12;
`endif

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mux_scan_nto1 #(.N_CH(16), .DATA_W(8), .DWELL_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .sel(sel),
    .ch_mask(ch_mask), .dwell(dwell), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_SCAN_PARITY_EN
    .out_par(out_par),
`endif
    .sel_err(sel_err));

  mux_scan_nto1 #(.N_CH(12), .DATA_W(8), .DWELL_W(8)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data12), .mode(1'b0), .sel(sel12),
    .ch_mask(12'h000), .dwell(8'd0), .out_data(out_data12), .out_ch(out_ch12),
    .out_valid(out_valid12), .out_ready(1'b1),
`ifdef MUX_SCAN_PARITY_EN
    .out_par(out_par12),
`endif
    .sel_err(sel_err12));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq[5];
    int w;
    exp_seq = '{0, 2, 15, 0, 2};
    rst_n = 1'b0; mode = 1'b0; sel = 4'd0; ch_mask = 16'h0; dwell = 8'd0; out_ready = 1'b1;
    sel12 = 4'd0;
    for (int k = 0; k < 16; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 12; k++) in_data12[k*8 +: 8] = 8'h10 + 8'(k);
    in_data12[2*8 +: 8] = 8'h07;
    in_data12[3*8 +: 8] = 8'h03;

    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_ch", {28'd0, out_ch}, 32'd0);
    chk("rst_err", {31'd0, sel_err}, 32'd0);
    rst_n = 1'b1;
    tick(); tick(); tick();

    // Manual back-to-back
    sel = 4'd3;  tick();
    chk("man3_v", {31'd0, out_valid}, 32'd1);
    chk("man3_d", {24'd0, out_data}, 32'h13);
    chk("man3_c", {28'd0, out_ch}, 32'd3);
    sel = 4'd7;  tick();
    chk("man7_d", {24'd0, out_data}, 32'h17);
    chk("man7_c", {28'd0, out_ch}, 32'd7);
    sel = 4'd15; tick();
    chk("man15_d", {24'd0, out_data}, 32'h1f);
    chk("man15_c", {28'd0, out_ch}, 32'd15);

    // Backpressure
    sel = 4'd5; tick();
    chk("bp_first", {24'd0, out_data}, 32'h15);
    out_ready = 1'b0; sel = 4'd9;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_d", {24'd0, out_data}, 32'h15);
      chk("bp_hold_c", {28'd0, out_ch}, 32'd5);
      chk("bp_hold_v", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1; tick();
    chk("bp_next_d", {24'd0, out_data}, 32'h19);
    chk("bp_next_c", {28'd0, out_ch}, 32'd9);

    // Scan with mask 8005, dwell 2
    mode = 1'b1; ch_mask = 16'h8005; dwell = 8'd2;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) begin
        tick(); chk("scan_gap1", {31'd0, out_valid}, 32'd0);
        tick(); chk("scan_gap2", {31'd0, out_valid}, 32'd0);
      end
      tick();
      chk("scan_v", {31'd0, out_valid}, 32'd1);
      chk("scan_c", {28'd0, out_ch}, 32'(exp_seq[s]));
      chk("scan_d", {24'd0, out_data}, 32'h10 + 32'(exp_seq[s]));
    end

    // Empty mask
    ch_mask = 16'h0;
    for (int i = 0; i < 8; i++) begin
      tick(); chk("mask0_v", {31'd0, out_valid}, 32'd0);
    end
    // Single channel, no dwell: every cycle
    ch_mask = 16'h0010; dwell = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("single_v", {31'd0, out_valid}, 32'd1);
      chk("single_c", {28'd0, out_ch}, 32'd4);
      chk("single_d", {24'd0, out_data}, 32'h14);
    end

    // Mode switch with pending scan sample
    out_ready = 1'b0; tick();
    mode = 1'b0; sel = 4'd7;
    tick(); tick();
    chk("msw_hold_c", {28'd0, out_ch}, 32'd4);
    chk("msw_hold_d", {24'd0, out_data}, 32'h14);
    chk("msw_hold_v", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1; tick();
    chk("msw_man_c", {28'd0, out_ch}, 32'd7);
    chk("msw_man_d", {24'd0, out_data}, 32'h17);

    // Async reset mid-stream
    mode = 1'b1; ch_mask = 16'h8005; tick();
    chk("pre_rst_v", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_c", {28'd0, out_ch}, 32'd15);
    rst_n = 1'b0; #1;
    chk("arst_v", {31'd0, out_valid}, 32'd0);
    chk("arst_d", {24'd0, out_data}, 32'd0);
    chk("arst_c", {28'd0, out_ch}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    w = 0;
    while (!out_valid && w < 10) begin tick(); w++; end
    chk("rst_restart_timeout", {31'd0, out_valid}, 32'd1);
    chk("rst_restart_c", {28'd0, out_ch}, 32'd0);

    // Range error on the 12-channel instance
    sel12 = 4'd13; tick();
    chk("err12_v", {31'd0, out_valid12}, 32'd0);
    chk("err12_pulse", {31'd0, sel_err12}, 32'd1);
    sel12 = 4'd2; tick();
    chk("err12_clear", {31'd0, sel_err12}, 32'd0);
    chk("ch2_12_d", {24'd0, out_data12}, 32'h07);
`ifdef MUX_SCAN_PARITY_EN
    chk("par_07", {31'd0, out_par12}, 32'd1);
`endif
    sel12 = 4'd3; tick();
    chk("ch3_12_d", {24'd0, out_data12}, 32'h03);
`ifdef MUX_SCAN_PARITY_EN
    chk("par_03", {31'd0, out_par12}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
